// File: rtl/clk_switch_seq.sv
// Glitch-free clock source switch sequencer: gates the downstream mux, swaps the select, re-enables it.
// Optional post-switch reset request pulse is built when CLK_SWITCH_SEQ_RST_REQ_EN is defined.
module clk_switch_seq #(
    parameter int unsigned SETTLE_CYCLES   = 8,
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter logic [1:0]  RESET_SEL       = 2'b00
) (
    input  logic       ref_clk_i,
    input  logic       arst_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    output logic [1:0] sel_o,
    output logic       en_o,
    output logic       arst_req_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEL_W = 2;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    // INIT has no entry edge to load on, so its first edge loads one less.
    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'((SETTLE_CYCLES > 1) ? (SETTLE_CYCLES - 2) : 0);
    localparam logic             INIT_SHORT  = (SETTLE_CYCLES == 1);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("clk_switch_seq: SETTLE_CYCLES out of range 1..255");
    end
    if ((RST_HOLD_CYCLES < 1) || (RST_HOLD_CYCLES > 255)) begin : g_bad_hold
        $error("clk_switch_seq: RST_HOLD_CYCLES out of range 1..255");
    end

`ifdef CLK_SWITCH_SEQ_RST_REQ_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_OFF, S_SETTLE, S_HOLD, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_OFF, S_SETTLE, S_DONE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic [SEL_W-1:0] sel_d;
    logic             en_d;
    logic             armed_q, armed_d;
    logic             arst_req_q, arst_req_d;
    logic             done_d, busy_d, ready_d;

    always_ff @(posedge ref_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            target_q    <= RESET_SEL;
            sel_o       <= RESET_SEL;
            en_o        <= 1'b0;
            armed_q     <= 1'b0;
            arst_req_q  <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b1;
            req_ready_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            sel_o       <= sel_d;
            en_o        <= en_d;
            armed_q     <= armed_d;
            arst_req_q  <= arst_req_d;
            done_o      <= done_d;
            busy_o      <= busy_d;
            req_ready_o <= ready_d;
        end
    end

    // Next-state, counter and output-register next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        sel_d      = sel_o;
        en_d       = en_o;
        armed_d    = armed_q;
        arst_req_d = arst_req_q;

        case (state_q)
            S_INIT: begin
                if (armed_q ? (cnt_q == '0) : INIT_SHORT) begin
                    en_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (!armed_q) begin
                    cnt_d   = INIT_LOAD;
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    if ((req_sel_i == sel_o) && en_o) begin
                        state_d = S_DONE;
                    end else begin
                        target_d = req_sel_i;
                        en_d     = 1'b0;
                        cnt_d    = SETTLE_LOAD;
                        state_d  = S_OFF;
                    end
                end
            end
            S_OFF: begin
                if (cnt_q == '0) begin
                    sel_d   = target_q;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    en_d = 1'b1;
`ifdef CLK_SWITCH_SEQ_RST_REQ_EN
                    arst_req_d = 1'b1;
                    cnt_d      = HOLD_LOAD;
                    state_d    = S_HOLD;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef CLK_SWITCH_SEQ_RST_REQ_EN
            S_HOLD: begin
                if (cnt_q == '0) begin
                    arst_req_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

`ifdef CLK_SWITCH_SEQ_RST_REQ_EN
    assign arst_req_o = arst_req_q;
`else
    assign arst_req_o = 1'b0;
`endif

endmodule
